conv1d_mem_arbiter: RTL
=======================

Name: conv1d_mem_arbiter

Overview:
- Sequences and shares the conv1d single-port internal SRAM (128 x 32 bit) between two requesters: the external port (OBI-to-SRAM bridge, host CPU/DMA) and the accelerator datapath.
- Grants one access per cycle and routes the one-cycle-latency read data back to the granted requester.
- Supports an exclusive accelerator lock for the whole run.
- Bounds external starvation in shared mode.
- Sits between the bridge/accelerator and the SRAM wrapper, replacing the plain memory multiplexer.

Parameters:
- NUM_WORDS, 128, SRAM depth; AW = $clog2(NUM_WORDS).
- DATA_WIDTH, 32, data width; BE width = DATA_WIDTH/8.
- MAX_EXT_WAIT, 4, consecutive stalled external cycles before external wins a conflict; must be >= 1.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; synchronous, active-high.
- ext_req_i / acc_req_i  in  1  access request.
- ext_we_i / acc_we_i  in  1  write enable.
- ext_be_i / acc_be_i  in  DATA_WIDTH/8  byte enables.
- ext_addr_i / acc_addr_i  in  AW  word address.
- ext_wdata_i / acc_wdata_i  in  DATA_WIDTH  write data.
- ext_gnt_o / acc_gnt_o  out  1  request granted this cycle.
- ext_rvalid_o / acc_rvalid_o  out  1  response for the previous-cycle grant.
- ext_rdata_o / acc_rdata_o  out  DATA_WIDTH  read data, valid with rvalid.
- acc_lock_i  in  1  accelerator requests exclusive ownership.
- lock_ack_o  out  1  exclusive ownership in effect.
- mem_req_o, mem_we_o  out  1  SRAM request/write enable.
- mem_be_o  out  DATA_WIDTH/8  SRAM byte enables.
- mem_addr_o  out  AW  SRAM address.
- mem_wdata_o  out  DATA_WIDTH  SRAM write data.
- mem_rdata_i  in  DATA_WIDTH  SRAM read data, one cycle after request.
- busy_o  out  1  a grant was issued this cycle, or a response is pending.

Behaviour:

Reset:
- While rst_i=1: all outputs 0, no grants, mem_req_o=0.
- Registered state after reset: FSM=SHARED, ext_wait_q=0, rvalid pipes cleared.
- Reset mid-transaction drops any pending rvalid; no response is delivered.

Grant timing:
- Grants are combinational in the cycle of the request (SRAM-style).
- An ungranted requester must hold its request and fields stable until granted.
- At most one of ext_gnt_o/acc_gnt_o is high per cycle.
- mem_* outputs take the granted requester's fields. With no grant, all mem_* outputs are 0.

Response timing:
- Every grant (read or write) produces that requester's rvalid exactly one cycle later.
- Owner is tracked in an ext_rv_q/acc_rv_q register pair.
- x_rdata_o = mem_rdata_i when x_rvalid_o=1, else 0.
- Back-to-back grants give one access per cycle at full throughput.

FSM:
- SHARED: lock_ack_o=0.
  - Single requester: granted.
  - Both requesting: acc wins, unless ext_wait_q >= MAX_EXT_WAIT, in which case ext wins.
  - acc_lock_i=1 -> DRAIN.
- DRAIN: one cycle; ext_gnt_o forced 0; acc granted if requesting; any ext rvalid from the last SHARED cycle is still delivered.
  - acc_lock_i=1 -> LOCKED.
  - acc_lock_i=0 -> SHARED.
- LOCKED: lock_ack_o=1; ext never granted; acc granted whenever requesting.
  - acc_lock_i=0 -> SHARED; lock_ack_o falls on the same edge.
- acc_lock_i is sampled at the clock edge. The first cycle with acc_lock_i=1 is still SHARED arbitration, and ext may win it.

Starvation counter (ext_wait_q, width $clog2(MAX_EXT_WAIT+1)):
- Increments, saturating, each SHARED cycle with ext_req_i=1 and ext_gnt_o=0.
- Clears when ext is granted or ext_req_i=0.
- Holds its value in DRAIN and LOCKED.

busy_o = ext_rv_q | acc_rv_q | mem_req_o.

Optional Feature:
- Macro: CONV1D_ARB_PERF_EN.
- Defined: adds output conflict_cnt_o [31:0].
  - Saturating count of cycles where a requester is stalled: both request in SHARED, or ext_req_i=1 in DRAIN/LOCKED.
  - Cleared by rst_i.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Reset, then single ext read at addr 5 (SRAM preloaded 0xDEAD_BEEF at addr 5) -> ext_gnt_o=1 in cycle 0, mem_addr_o=5; ext_rvalid_o=1 with ext_rdata_o=0xDEAD_BEEF in cycle 1; acc_rvalid_o=0 throughout.
- Both requesters held high continuously in SHARED, MAX_EXT_WAIT=4 -> grant pattern acc,acc,acc,acc,ext repeating; each rvalid lands one cycle after its own grant.
- ext_req_i high, pulse acc_lock_i -> next cycle DRAIN with ext_gnt_o=0; following cycle lock_ack_o=1; ext never granted while locked. Drop lock -> SHARED and lock_ack_o=0 after one edge; pending ext granted immediately if acc idle.
- Accelerator burst of 8 writes (addr 0..7, data i*3) in LOCKED, then 8 reads -> 8 back-to-back gnts; read data 0,3,...,21 returned in order, one per cycle.
- Assert rst_i in the cycle after an acc read grant -> acc_rvalid_o stays 0, all outputs 0 next cycle, FSM SHARED, lock_ack_o=0.
- With CONV1D_ARB_PERF_EN: 10 cycles of simultaneous requests in SHARED -> conflict_cnt_o=10; rst_i returns it to 0.

Source files
------------

// File: rtl/conv1d_mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | conv1d_mem_arbiter: shares the conv1d SRAM between external port and     |
// | accelerator. Optional CONV1D_ARB_PERF_EN adds conflict_cnt_o.  Rev 1.0   |
// +--------------------------------------------------------------------------+
module conv1d_mem_arbiter #(
   parameter int NUM_WORDS    = 128,
   parameter int DATA_WIDTH   = 32,
   parameter int MAX_EXT_WAIT = 4,
   localparam int AW = $clog2(NUM_WORDS),
   localparam int BW = DATA_WIDTH / 8,
   localparam int WW = $clog2(MAX_EXT_WAIT + 1)
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  ext_req_i,
   input  logic                  ext_we_i,
   input  logic [BW-1:0]         ext_be_i,
   input  logic [AW-1:0]         ext_addr_i,
   input  logic [DATA_WIDTH-1:0] ext_wdata_i,
   output logic                  ext_gnt_o,
   output logic                  ext_rvalid_o,
   output logic [DATA_WIDTH-1:0] ext_rdata_o,
   input  logic                  acc_req_i,
   input  logic                  acc_we_i,
   input  logic [BW-1:0]         acc_be_i,
   input  logic [AW-1:0]         acc_addr_i,
   input  logic [DATA_WIDTH-1:0] acc_wdata_i,
   output logic                  acc_gnt_o,
   output logic                  acc_rvalid_o,
   output logic [DATA_WIDTH-1:0] acc_rdata_o,
   input  logic                  acc_lock_i,
   output logic                  lock_ack_o,
   output logic                  mem_req_o,
   output logic                  mem_we_o,
   output logic [BW-1:0]         mem_be_o,
   output logic [AW-1:0]         mem_addr_o,
   output logic [DATA_WIDTH-1:0] mem_wdata_o,
   input  logic [DATA_WIDTH-1:0] mem_rdata_i,
   output logic                  busy_o
`ifdef CONV1D_ARB_PERF_EN
  ,output logic [31:0]           conflict_cnt_o
`endif
);

   typedef enum logic [1:0] {
      ST_SHARED = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_LOCKED = 2'd2
   } state_t;

   localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_EXT_WAIT);

   state_t        state_q, state_d;
   logic [WW-1:0] ext_wait_q, ext_wait_d;
   logic          ext_rv_q, ext_rv_d;
   logic          acc_rv_q, acc_rv_d;
   logic          ext_gnt, acc_gnt;

   always_comb begin
      ext_gnt    = 1'b0;
      acc_gnt    = 1'b0;
      state_d    = state_q;
      ext_wait_d = ext_wait_q;
      case (state_q)
         ST_SHARED: begin
            if (ext_req_i && acc_req_i) begin
               if (ext_wait_q >= WAIT_MAX) ext_gnt = 1'b1;
               else                        acc_gnt = 1'b1;
            end else begin
               ext_gnt = ext_req_i;
               acc_gnt = acc_req_i;
            end
            if (ext_req_i && !ext_gnt)
               ext_wait_d = (ext_wait_q >= WAIT_MAX) ? WAIT_MAX : ext_wait_q + 1'b1;
            else
               ext_wait_d = '0;
            if (acc_lock_i) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            acc_gnt = acc_req_i;
            state_d = acc_lock_i ? ST_LOCKED : ST_SHARED;
         end
         ST_LOCKED: begin
            acc_gnt = acc_req_i;
            if (!acc_lock_i) state_d = ST_SHARED;
         end
         default: state_d = ST_SHARED;
      endcase
      // Grants are combinational, so reset must suppress them in the same cycle.
      if (rst_i) begin
         ext_gnt = 1'b0;
         acc_gnt = 1'b0;
      end
      ext_rv_d = ext_gnt;
      acc_rv_d = acc_gnt;
   end

   always_comb begin
      mem_req_o   = ext_gnt | acc_gnt;
      mem_we_o    = 1'b0;
      mem_be_o    = '0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      if (ext_gnt) begin
         mem_we_o    = ext_we_i;
         mem_be_o    = ext_be_i;
         mem_addr_o  = ext_addr_i;
         mem_wdata_o = ext_wdata_i;
      end else if (acc_gnt) begin
         mem_we_o    = acc_we_i;
         mem_be_o    = acc_be_i;
         mem_addr_o  = acc_addr_i;
         mem_wdata_o = acc_wdata_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= ST_SHARED;
         ext_wait_q <= '0;
         ext_rv_q   <= 1'b0;
         acc_rv_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         ext_wait_q <= ext_wait_d;
         ext_rv_q   <= ext_rv_d;
         acc_rv_q   <= acc_rv_d;
      end
   end

   assign ext_gnt_o    = ext_gnt;
   assign acc_gnt_o    = acc_gnt;
   assign ext_rvalid_o = ext_rv_q & ~rst_i;
   assign acc_rvalid_o = acc_rv_q & ~rst_i;
   assign ext_rdata_o  = ext_rvalid_o ? mem_rdata_i : '0;
   assign acc_rdata_o  = acc_rvalid_o ? mem_rdata_i : '0;
   assign lock_ack_o   = (state_q == ST_LOCKED) & ~rst_i;
   assign busy_o       = ((ext_rv_q | acc_rv_q) & ~rst_i) | mem_req_o;

`ifdef CONV1D_ARB_PERF_EN
   logic [31:0] conflict_cnt_q, conflict_cnt_d;
   logic        stall;

   always_comb begin
      stall          = (state_q == ST_SHARED) ? (ext_req_i & acc_req_i) : ext_req_i;
      conflict_cnt_d = conflict_cnt_q;
      if (stall && (conflict_cnt_q != 32'hFFFF_FFFF))
         conflict_cnt_d = conflict_cnt_q + 32'd1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) conflict_cnt_q <= '0;
      else       conflict_cnt_q <= conflict_cnt_d;
   end

   assign conflict_cnt_o = rst_i ? 32'd0 : conflict_cnt_q;
`endif

endmodule
`default_nettype wire
